// File: rtl/password_match_ctrl_if.sv
// password_match_ctrl_if: shared Address bus, ROM/RAM read data and compare status between controller and memories.
interface password_match_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_FAILS  = 3
);
  logic                             start;
  logic [ADDR_WIDTH-1:0]            Address;
  logic [DATA_WIDTH-1:0]            Data_ROM;
  logic [DATA_WIDTH-1:0]            Data_RAM;
  logic                             busy;
  logic                             done;
  logic                             match;
  logic                             locked;
  logic [$clog2(MAX_FAILS+1)-1:0]   fail_count;
  modport master (
    input  start, Data_ROM, Data_RAM,
    output Address, busy, done, match, locked, fail_count
  );
  modport slave (
    output start, Data_ROM, Data_RAM,
    input  Address, busy, done, match, locked, fail_count
  );
endinterface

// File: rtl/password_match_ctrl.sv
// password_match_ctrl: walks PW_LEN words of ROM and RAM, compares them in constant time,
// counts consecutive failures and enforces a timed lockout.
module password_match_ctrl #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    PW_LEN         = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 64
) (
  input logic                 clk,
  input logic                 rst,
  password_match_ctrl_if.master bus
);
  localparam int CW = $clog2(PW_LEN + 2);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE, LOCK} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          mis_q, mis_d;
  logic          match_q, match_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      mis_q   <= 1'b0;
      match_q <= 1'b0;
      fail_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      mis_q   <= mis_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
    end
  // cyc_q counts edges since entering RUN; word k is compared while cyc_q == k+1
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    mis_d   = mis_q;
    match_d = match_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        cyc_d   = '0;
        mis_d   = 1'b0;
      end
      RUN: begin
        cyc_d = cyc_q + CW'(1);
        mis_d = (cyc_q != '0) ? (mis_q | (bus.Data_ROM != bus.Data_RAM)) : mis_q;
        if (cyc_q == CW'(PW_LEN)) begin
          state_d = DONE;
          match_d = ~mis_d;
          fail_d  = !mis_d ? '0 : (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
        end
      end
      DONE: begin
        state_d = (fail_q == FW'(MAX_FAILS)) ? LOCK : IDLE;
        lock_d  = LW'(LOCKOUT_CYCLES);
      end
      default: begin
        lock_d = lock_q - LW'(1);
        if (lock_q == LW'(1)) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
    endcase
  end
  always_comb begin
    bus.Address    = BASE_ADDR + ((state_q == RUN) ?
                     ADDR_WIDTH'((cyc_q >= CW'(PW_LEN - 1)) ? CW'(PW_LEN - 1) : cyc_q) : '0);
    bus.busy       = (state_q == RUN) || (state_q == DONE);
    bus.done       = state_q == DONE;
    bus.locked     = state_q == LOCK;
    bus.match      = match_q;
    bus.fail_count = fail_q;
  end
endmodule

// File: tb/tb_password_match_ctrl.sv
// tb_password_match_ctrl: directed and randomized compare runs against a behavioural
// model of the password check, lockout and address walk.
module tb_password_match_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  password_match_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_FAILS(3)) b();
  password_match_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_FAILS(3)) b2();
  password_match_ctrl dut (.clk(clk), .rst(rst), .bus(b));
  password_match_ctrl #(.BASE_ADDR(16'hFFFE)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  logic [15:0] rom [4];
  logic [15:0] ram [4];
  int n_chk = 0, n_fail = 0, fails_m = 0;
  assign b2.start = b.start;
  always @(posedge clk) begin
    b.Data_ROM  <= rom[b.Address[1:0]];
    b.Data_RAM  <= ram[b.Address[1:0]];
    b2.Data_ROM <= rom[2'(b2.Address + 16'd2)];
    b2.Data_RAM <= ram[2'(b2.Address + 16'd2)];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_addr", b.Address, 32'h0);
    chk("rst_addr2", b2.Address, 32'hFFFE);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_match", b.match, 0);
    chk("rst_locked", b.locked, 0);
    chk("rst_fails", b.fail_count, 0);
  endtask
  task automatic fill(input bit mismatch);
    for (int k = 0; k < 4; k++) begin
      rom[k] = 16'($urandom);
      ram[k] = rom[k];
    end
    if (mismatch) begin
      int k;
      k = $urandom_range(0, 3);
      ram[k] = rom[k] ^ 16'($urandom_range(1, 16'hFFFF));
    end
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk_reset();
    fails_m = 0;
    b.start = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_done", b.done, 0);
  endtask
  task automatic run(input bit noise, input int rst_lock_at);
    bit m;
    m = 1'b1;
    for (int k = 0; k < 4; k++) if (rom[k] !== ram[k]) m = 1'b0;
    b.start = 1'b1;
    step();
    b.start = noise;
    for (int j = 0; j < 5; j++) begin
      chk("addr", b.Address, 32'(j > 3 ? 3 : j));
      chk("addr_wrap", b2.Address, 32'(16'(16'hFFFE + 16'(j > 3 ? 3 : j))));
      chk("busy_run", b.busy, 1);
      chk("done_early", b.done, 0);
      step();
    end
    fails_m = m ? 0 : (fails_m < 3 ? fails_m + 1 : 3);
    chk("done", b.done, 1);
    chk("match", b.match, 32'(m));
    chk("fail_count", b.fail_count, 32'(fails_m));
    chk("busy_done", b.busy, 1);
    b.start = 1'b0;
    step();
    chk("done_pulse", b.done, 0);
    chk("busy_after", b.busy, 0);
    chk("locked", b.locked, 32'(fails_m == 3));
    if (fails_m == 3) begin
      b.start = 1'b1;
      for (int i = 1; i < 64; i++) begin
        step();
        if (i == rst_lock_at) begin
          apply_reset();
          return;
        end
        chk("lock_hold", b.locked, 1);
        chk("lock_ignore_start", b.busy, 0);
        chk("lock_fails", b.fail_count, 3);
      end
      b.start = 1'b0;
      step();
      chk("lock_release", b.locked, 0);
      chk("lock_fail_clr", b.fail_count, 0);
      chk("lock_busy", b.busy, 0);
      fails_m = 0;
    end
  endtask
  initial begin
    b.start = 1'b0;
    fill(1'b0);
    step();
    step();
    chk_reset();
    rst = 1'b0;
    step();
    run(1'b0, -1);
    fill(1'b0);
    rom[3] = 16'h1234;
    ram[3] = 16'hAAAA;
    run(1'b0, -1);
    fill(1'b0);
    run(1'b0, -1);
    fill(1'b0);
    run(1'b1, -1);
    repeat (3) begin
      fill(1'b1);
      run(1'b0, -1);
    end
    repeat (8) begin
      fill(bit'($urandom_range(0, 1)));
      run(bit'($urandom_range(0, 1)), -1);
    end
    fill(1'b0);
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    step();
    step();
    apply_reset();
    run(1'b0, -1);
    repeat (3) begin
      fill(1'b1);
      run(1'b0, 20);
    end
    chk("lock_rst_locked", b.locked, 0);
    fill(1'b0);
    run(1'b0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
